pipeline_reg_stage: RTL and testbench

//  Parametrised successor to the plain 32-bit register: one pipeline stage register with a valid/ready handshake.
//  Two-entry skid buffer: full throughput (1 word/cycle), fully registered ready path.

---
 rtl/pipeline_reg_stage.sv | 134 +++++++++++++
 tb/tb_pipeline_reg_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_reg_stage.sv
// One pipeline stage register with a valid/ready handshake, built as a two-entry skid buffer.
// Optional synchronous flush is compiled in with `define PIPE_REG_FLUSH_EN.
module pipeline_reg_stage #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_reg,
  input  logic             flush
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             accept_s;
  logic             drain_s;
  logic             flush_s;
  logic             load_main_in_s;
  logic             load_main_skid_s;
  logic             load_skid_s;

`ifdef PIPE_REG_FLUSH_EN
  assign flush_s = flush;
`else
  // The port is kept for a uniform interface; nothing reads it in this build.
  logic unused_flush_s;
  assign unused_flush_s = flush;
  assign flush_s        = 1'b0;
`endif

  // Handshake events use only registered ready/valid, so no input reaches an output combinationally.
  assign accept_s = in_valid & in_ready_r;
  assign drain_s  = out_valid_r & out_ready;

  // Next-state and data-load decode; flush overrides every transition.
  always_comb begin
    state_next_s     = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush_s) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_next_s   = BUSY;
            load_main_in_s = 1'b1;
          end else begin
            state_next_s = EMPTY;
          end
        end
        BUSY: begin
          if (accept_s && drain_s) begin
            state_next_s   = BUSY;
            load_main_in_s = 1'b1;
          end else if (accept_s) begin
            state_next_s = FULL;
            load_skid_s  = 1'b1;
          end else if (drain_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = BUSY;
          end
        end
        FULL: begin
          if (drain_s) begin
            state_next_s     = BUSY;
            load_main_skid_s = 1'b1;
          end else begin
            state_next_s = FULL;
          end
        end
        default: begin
          state_next_s = EMPTY;
        end
      endcase
    end
  end

  // State and the handshake outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != EMPTY);
      in_ready_r  <= (state_next_s != FULL);
    end
  end

  // Main and skid data registers; these are not cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_r <= RESET_VALUE;
      skid_r <= RESET_VALUE;
    end else begin
      if (load_main_in_s) begin
        main_r <= input_reg;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= input_reg;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign output_reg = main_r;
  assign out_valid  = out_valid_r;
  assign in_ready   = in_ready_r;

endmodule

// File: tb/tb_pipeline_reg_stage.sv
// Self-checking bench for pipeline_reg_stage: a queue scoreboard follows every handshake,
// and per-scenario tasks add directed checks.
module tb_pipeline_reg_stage;

  localparam int          W  = 32;
  localparam logic [W-1:0] RV = 32'h0000_00A5;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] input_reg = 32'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] output_reg;
  logic         flush = 1'b0;

  int errors = 0;
  int checks = 0;
  int drained = 0;
  logic [W-1:0] q[$];

  pipeline_reg_stage #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .input_reg(input_reg), .out_valid(out_valid), .out_ready(out_ready),
    .output_reg(output_reg), .flush(flush)
  );

  always #5 clock = ~clock;

  // Scoreboard: check outputs against the queue model, then apply the coming edge's events.
  always @(negedge clock) begin
    logic flush_act;
    logic exp_v;
    logic exp_r;
`ifdef PIPE_REG_FLUSH_EN
    flush_act = flush;
`else
    flush_act = 1'b0;
`endif
    if (!reset_n) begin
      q.delete();
    end else begin
      exp_v = (q.size() != 0);
      exp_r = (q.size() < 2);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_v);
      end
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_r);
      end
      if (q.size() != 0) begin
        checks++;
        if (output_reg !== q[0]) begin
          errors++;
          $display("FAIL sb_data t=%0t got=%h exp=%h", $time, output_reg, q[0]);
        end
      end
      if (flush_act) begin
        q.delete();
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          void'(q.pop_front());
          drained++;
        end
        if (in_valid && in_ready) q.push_back(input_reg);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Stimulus helper: present one word for one edge (caller ensures in_ready).
  task automatic push_word(input logic [W-1:0] w);
    in_valid  = 1'b1;
    input_reg = w;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || output_reg !== RV) begin
      errors++;
      $display("FAIL reset_init got=%b/%b/%h exp=0/1/%h", out_valid, in_ready, output_reg, RV);
    end
    reset_n = 1'b1;
    step();
    out_ready = 1'b0;
    push_word(32'h11);
    push_word(32'h22);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill got=%b/%b exp=1/0", out_valid, in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || output_reg !== RV) begin
      errors++;
      $display("FAIL reset_async got=%b/%b/%h exp=0/1/%h", out_valid, in_ready, output_reg, RV);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_stream();
    int low;
    low = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!in_ready) low++;
      in_valid  = 1'b1;
      input_reg = W'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || output_reg !== W'(i)) begin
        errors++;
        $display("FAIL stream_latency i=%0d got=%b/%h exp=1/%h", i, out_valid, output_reg, W'(i));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (low != 0) begin
      errors++;
      $display("FAIL stream_in_ready low_cycles=%0d exp=0", low);
    end
    drain_all();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    logic acc;
    out_ready = 1'b0;
    push_word(32'h0A);
    push_word(32'h0B);
    in_valid  = 1'b1;
    input_reg = 32'h0C;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || output_reg !== 32'h0A) begin
        errors++;
        $display("FAIL bp_hold k=%0d got=%b/%b/%h exp=1/0/0a", k, out_valid, in_ready, output_reg);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      acc = in_valid && in_ready;
      if (out_valid) got.push_back(output_reg);
      step();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL bp_count got=%0d exp=3", got.size());
    end else begin
      checks++;
      if (got[0] !== 32'h0A || got[1] !== 32'h0B || got[2] !== 32'h0C) begin
        errors++;
        $display("FAIL bp_order got=%h %h %h exp=0a 0b 0c", got[0], got[1], got[2]);
      end
    end
    drain_all();
  endtask

  task automatic test_full_drain();
    out_ready = 1'b0;
    push_word(32'h0A);
    push_word(32'h0B);
    in_valid  = 1'b1;
    input_reg = 32'h0C;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || output_reg !== 32'h0B) begin
      errors++;
      $display("FAIL full_drain got=%b/%b/%h exp=1/1/0b", out_valid, in_ready, output_reg);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_no_accept got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    out_ready = 1'b0;
    push_word(32'h1A);
    push_word(32'h1B);
    in_valid  = 1'b1;
    input_reg = 32'h1C;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
`ifdef PIPE_REG_FLUSH_EN
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty got=%b/%b exp=0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (5) begin
      if (out_valid) seen++;
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_words_seen got=%0d exp=0", seen);
    end
`else
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || output_reg !== 32'h1A) begin
      errors++;
      $display("FAIL flush_ignored got=%b/%b/%h exp=1/0/1a", out_valid, in_ready, output_reg);
    end
    drain_all();
`endif
  endtask

  task automatic test_random();
    int sent;
    int base;
    int cyc;
    sent = 0;
    cyc  = 0;
    base = drained;
    while (sent < 1000 && cyc < 20000) begin
      in_valid  = ($urandom % 3) != 0;
      input_reg = 32'h5000_0000 + W'(sent);
      out_ready = ($urandom % 2) != 0;
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    drain_all();
    checks++;
    if (sent != 1000 || drained - base != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL random_totals sent=%0d drained=%0d left=%0d exp=1000/1000/0",
               sent, drained - base, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_full_drain();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
